core_exu_result_stage: RTL and testbench
========================================

Name: core_exu_result_stage

Overview:
- Downstream neighbour of the execute sub-units (shift, ALU, MDU) in the rv32 core.
- Each cycle it merges the sub-units' `*_enable` / `*_data_out` pairs into one execute result.
- Tags the result with destination-register info and holds it in a small FIFO (skid buffer) toward the write-back stage.
- Decouples execute from write-back stalls with a valid/ready handshake on both sides.

Parameters:
- DEPTH, 2, FIFO entries; legal values 2..8.
- PTR_W, 3, pointer/count width; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  execute stage presents an instruction result this cycle.
- in_ready  output  1  stage can accept; equals (count < DEPTH).
- in_rd  input  5  destination register index.
- in_rd_wen  input  1  instruction writes rd.
- shift_enable  input  1  shift unit owns this result.
- shift_data_out  input  32  shift unit result.
- alu_enable  input  1  ALU owns this result.
- alu_data_out  input  32  ALU result.
- mdu_enable  input  1  mul/div unit owns this result.
- mdu_data_out  input  32  MDU result.
- flush  input  1  pipeline flush; discards all held and incoming results.
- out_valid  output  1  head entry valid toward write-back.
- out_ready  input  1  write-back accepts head.
- out_rd  output  5  head rd.
- out_rd_wen  output  1  head write enable.
- out_data  output  32  head result.
- out_conflict  output  1  head entry was built from more than one asserted enable.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is synchronous, active-low.
  - While rst_n=0 at a clk edge: count=0, write/read pointers=0, all storage cleared.
- Reset values of outputs:
  - out_valid=0, out_rd=0, out_rd_wen=0, out_data=0, out_conflict=0.
  - in_ready=1 once reset is released; in_ready=0 while rst_n=0.
- Result merge (combinational, on the input side):
  - Priority is shift > alu > mdu.
  - Selected data is the first asserted unit's data. If no enable is asserted, data=0.
  - conflict = more than one enable asserted.
  - Stored wen = in_rd_wen AND (in_rd != 0); rd=x0 never produces a write.
- Push and pop:
  - Push = in_valid & in_ready & ~flush.
  - Pop = out_valid & out_ready & ~flush.
  - Outputs are driven from the head entry (registered storage, no input-to-output combinational path).
  - out_valid = (count != 0).
  - Latency: a result pushed at edge N is visible on outputs after edge N when the FIFO was empty. No combinational bypass.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - Legal even when count=DEPTH: in_ready is 0 when full, so no push happens. No fall-through in the full case.
- Pointer wrap-around: pointers wrap modulo DEPTH (DEPTH need not be a power of two); explicit compare-and-clear.
- Empty: out_valid=0, and out_* hold their last popped values. Verification must only check out_* while out_valid=1.
- Flush (has priority over push and pop):
  - Next edge: count=0, pointers=0, out_valid=0; the incoming beat is dropped.
  - in_ready is unaffected combinationally.
- Reset mid-operation: reset overrides flush, push and pop; all entries are lost.
- Handshake rules:
  - Upstream may hold in_valid with changing data only when in_ready=0.
  - Once out_valid=1, the head entry stays stable until popped or flushed.

Optional Feature:
- Macro: CORE_EXU_RESULT_FWD_EN.
- When defined, add outputs:
  - fwd_valid (1)
  - fwd_rd (5)
  - fwd_data (32)
- Forwarding behaviour when defined:
  - Combinational bypass of the youngest valid entry with stored wen=1 (search from tail toward head).
  - Lets issue logic forward to rs1/rs2 before write-back.
  - fwd_valid=0 when no such entry exists, or during flush/reset state.
  - fwd_rd/fwd_data = 0 when fwd_valid=0.
- When undefined: the ports are absent and the search logic is not synthesized.

Test Plan:
- Reset then single push:
  - Stimulus: rst_n low 2 cycles; push shift_enable=1, shift_data_out=0x8000_0001, in_rd=5, in_rd_wen=1; out_ready=1.
  - Response: one cycle later out_valid=1, out_data=0x8000_0001, out_rd=5, out_rd_wen=1, out_conflict=0; next cycle out_valid=0.
- Fill and backpressure:
  - Stimulus: out_ready=0, push 3 beats (ALU data 0x11, 0x22, 0x33).
  - Response: in_ready=0 after the 2nd push; the 3rd is not accepted. Raise out_ready: outputs 0x11 then 0x22, then out_valid=0.
- Conflict, zero-enable and x0:
  - Stimulus A: shift_enable=alu_enable=1 (shift 0xAA, alu 0xBB).
  - Response A: out_data=0xAA, out_conflict=1.
  - Stimulus B: no enables.
  - Response B: out_data=0.
  - Stimulus C: in_rd=0, in_rd_wen=1.
  - Response C: out_rd_wen=0.
- Simultaneous push/pop at count=1 with wrap:
  - Stimulus: 10 consecutive beats 1..10 with out_ready=1 continuously.
  - Response: in-order outputs 1..10, no drops, count never exceeds 1.
- Flush with full FIFO plus concurrent in_valid:
  - Response: next cycle out_valid=0 and in_ready=1; the concurrent beat is never output.
- CORE_EXU_RESULT_FWD_EN:
  - Stimulus: out_ready=0; push rd=3 data 0x10, then rd=3 data 0x20.
  - Response: fwd_valid=1, fwd_rd=3, fwd_data=0x20.
  - Stimulus: flush.
  - Response: fwd_valid=0.

Source files
------------

// File: rtl/core_exu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : core_exu_result_stage
// Description : Execute result stage for the rv32 core.
//               - Merges the shift/ALU/MDU enable+data pairs into one result.
//                 Priority is shift > alu > mdu.
//               - Tags the result with rd and write-enable information.
//               - Queues it in a DEPTH-entry skid FIFO toward write-back.
//               Optional macro CORE_EXU_RESULT_FWD_EN adds a combinational
//               forwarding port that exposes the youngest queued writing entry.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready, in_rd, in_rd_wen, *_enable/*_data_out : execute side
//               flush                                                   : pipeline flush
//               out_valid/out_ready, out_rd, out_rd_wen, out_data,
//               out_conflict                                            : write-back side
//               fwd_valid, fwd_rd, fwd_data (only with CORE_EXU_RESULT_FWD_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module core_exu_result_stage #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic        shift_enable,
  input  logic [31:0] shift_data_out,
  input  logic        alu_enable,
  input  logic [31:0] alu_data_out,
  input  logic        mdu_enable,
  input  logic [31:0] mdu_data_out,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [31:0] out_data,
  output logic        out_conflict
`ifdef CORE_EXU_RESULT_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PTR_W + 1;

  // FIFO storage
  logic [31:0]      r_data [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic             r_wen  [DEPTH];
  logic             r_conf [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_count;

  // Last popped entry, shown on out_* while the FIFO is empty
  logic [31:0]      r_last_data;
  logic [4:0]       r_last_rd;
  logic             r_last_wen;
  logic             r_last_conf;

  logic [31:0]      w_sel_data;
  logic             w_conflict;
  logic             w_wen;
  logic             w_push;
  logic             w_pop;

  // Result merge
  always_comb begin
    w_sel_data = 32'd0;
    if (shift_enable)    w_sel_data = shift_data_out;
    else if (alu_enable) w_sel_data = alu_data_out;
    else if (mdu_enable) w_sel_data = mdu_data_out;
  end

  assign w_conflict = (shift_enable & alu_enable) | (shift_enable & mdu_enable) |
                      (alu_enable & mdu_enable);
  // x0 is hardwired zero, so it never takes a write
  assign w_wen      = in_rd_wen & (in_rd != 5'd0);

  assign in_ready  = rst_n & (r_count < PTR_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_data <= '0;
      r_last_rd   <= '0;
      r_last_wen  <= 1'b0;
      r_last_conf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
        r_wen[i]  <= 1'b0;
        r_conf[i] <= 1'b0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr[IDX_W-1:0]] <= w_sel_data;
        r_rd[r_wr_ptr[IDX_W-1:0]]   <= in_rd;
        r_wen[r_wr_ptr[IDX_W-1:0]]  <= w_wen;
        r_conf[r_wr_ptr[IDX_W-1:0]] <= w_conflict;
        r_wr_ptr                    <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_last_data <= r_data[r_rd_ptr[IDX_W-1:0]];
        r_last_rd   <= r_rd[r_rd_ptr[IDX_W-1:0]];
        r_last_wen  <= r_wen[r_rd_ptr[IDX_W-1:0]];
        r_last_conf <= r_conf[r_rd_ptr[IDX_W-1:0]];
        r_rd_ptr    <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PTR_W'(1);
        2'b01:   r_count <= r_count - PTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs come only from registered state
  always_comb begin
    out_data     = r_last_data;
    out_rd       = r_last_rd;
    out_rd_wen   = r_last_wen;
    out_conflict = r_last_conf;
    if (out_valid) begin
      out_data     = r_data[r_rd_ptr[IDX_W-1:0]];
      out_rd       = r_rd[r_rd_ptr[IDX_W-1:0]];
      out_rd_wen   = r_wen[r_rd_ptr[IDX_W-1:0]];
      out_conflict = r_conf[r_rd_ptr[IDX_W-1:0]];
    end
  end

`ifdef CORE_EXU_RESULT_FWD_EN
  logic [CW-1:0] w_idx;

  // Walk head to tail; later (younger) writing entries override earlier ones
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = 5'd0;
    fwd_data  = 32'd0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = {1'b0, r_rd_ptr} + CW'(i);
      if (w_idx >= CW'(DEPTH)) w_idx = w_idx - CW'(DEPTH);
      if ((CW'(i) < {1'b0, r_count}) && r_wen[w_idx[IDX_W-1:0]]) begin
        fwd_valid = 1'b1;
        fwd_rd    = r_rd[w_idx[IDX_W-1:0]];
        fwd_data  = r_data[w_idx[IDX_W-1:0]];
      end
    end
    if (flush || !rst_n) begin
      fwd_valid = 1'b0;
      fwd_rd    = 5'd0;
      fwd_data  = 32'd0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_exu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_exu_result_stage
// Description : Directed self-checking bench for core_exu_result_stage
//               (DEPTH=2). Inputs change #1 after the rising edge and outputs
//               are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_exu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        shift_enable;
  logic [31:0] shift_data_out;
  logic        alu_enable;
  logic [31:0] alu_data_out;
  logic        mdu_enable;
  logic [31:0] mdu_data_out;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_data;
  logic        out_conflict;
`ifdef CORE_EXU_RESULT_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int passes = 0;
  int total  = 0;

  core_exu_result_stage #(.DEPTH(2), .PTR_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_rd_wen      (in_rd_wen),
    .shift_enable   (shift_enable),
    .shift_data_out (shift_data_out),
    .alu_enable     (alu_enable),
    .alu_data_out   (alu_data_out),
    .mdu_enable     (mdu_enable),
    .mdu_data_out   (mdu_data_out),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rd         (out_rd),
    .out_rd_wen     (out_rd_wen),
    .out_data       (out_data),
    .out_conflict   (out_conflict)
`ifdef CORE_EXU_RESULT_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    shift_enable = 1'b0;
    alu_enable   = 1'b0;
    mdu_enable   = 1'b0;
    flush        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_rd = '0; in_rd_wen = 1'b0; out_ready = 1'b0;
    shift_data_out = '0; alu_data_out = '0; mdu_data_out = '0;
    idle_inputs();

    // Reset
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_rd_wen", 32'(out_rd_wen), 32'd0);
    check("rst_out_conflict", 32'(out_conflict), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single push
    out_ready = 1'b1; in_valid = 1'b1; shift_enable = 1'b1;
    shift_data_out = 32'h8000_0001; in_rd = 5'd5; in_rd_wen = 1'b1;
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", out_data, 32'h8000_0001);
    check("single_rd", 32'(out_rd), 32'd5);
    check("single_wen", 32'(out_rd_wen), 32'd1);
    check("single_conflict", 32'(out_conflict), 32'd0);
    idle_inputs();
    tick();
    check("single_drained", 32'(out_valid), 32'd0);

    // Fill and backpressure
    out_ready = 1'b0; in_valid = 1'b1; alu_enable = 1'b1; in_rd = 5'd7;
    alu_data_out = 32'h11; tick();
    check("fill1_in_ready", 32'(in_ready), 32'd1);
    alu_data_out = 32'h22; tick();
    check("fill2_in_ready", 32'(in_ready), 32'd0);
    alu_data_out = 32'h33; tick();
    check("fill3_in_ready", 32'(in_ready), 32'd0);
    idle_inputs();
    out_ready = 1'b1;
    check("drain_head0", out_data, 32'h11);
    tick();
    check("drain_valid1", 32'(out_valid), 32'd1);
    check("drain_head1", out_data, 32'h22);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Conflict: shift wins
    out_ready = 1'b0; in_valid = 1'b1; shift_enable = 1'b1; alu_enable = 1'b1;
    shift_data_out = 32'hAA; alu_data_out = 32'hBB; in_rd = 5'd1; in_rd_wen = 1'b1;
    tick();
    check("conflict_data", out_data, 32'hAA);
    check("conflict_flag", 32'(out_conflict), 32'd1);
    idle_inputs(); out_ready = 1'b1; tick();
    check("conflict_drained", 32'(out_valid), 32'd0);

    // No enables: data forced to zero
    out_ready = 1'b0; in_valid = 1'b1; in_rd = 5'd2;
    tick();
    check("noen_data", out_data, 32'd0);
    check("noen_conflict", 32'(out_conflict), 32'd0);
    idle_inputs(); out_ready = 1'b1; tick();

    // rd = x0 never writes
    out_ready = 1'b0; in_valid = 1'b1; mdu_enable = 1'b1; mdu_data_out = 32'h5;
    in_rd = 5'd0; in_rd_wen = 1'b1;
    tick();
    check("x0_wen", 32'(out_rd_wen), 32'd0);
    check("x0_mdu_data", out_data, 32'h5);
    idle_inputs(); out_ready = 1'b1; tick();
    check("x0_drained", 32'(out_valid), 32'd0);

    // Streaming push/pop with pointer wrap
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; mdu_enable = 1'b1; mdu_data_out = 32'(k);
      in_rd = 5'(k); in_rd_wen = 1'b1;
      tick();
      check($sformatf("stream_data_%0d", k), out_data, 32'(k));
      check($sformatf("stream_rd_%0d", k), 32'(out_rd), 32'(k));
      check($sformatf("stream_ready_%0d", k), 32'(in_ready), 32'd1);
    end
    idle_inputs(); tick();
    check("stream_empty", 32'(out_valid), 32'd0);

    // Flush a full FIFO with an incoming beat
    out_ready = 1'b0; in_valid = 1'b1; alu_enable = 1'b1; in_rd = 5'd9;
    alu_data_out = 32'h101; tick();
    alu_data_out = 32'h102; tick();
    check("pre_flush_full", 32'(in_ready), 32'd0);
    alu_data_out = 32'h999; flush = 1'b1;
    tick();
    idle_inputs();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    // Flush from empty with in_ready=1: the beat must still be dropped
    in_valid = 1'b1; alu_enable = 1'b1; alu_data_out = 32'h777; flush = 1'b1;
    tick();
    idle_inputs();
    check("flush_drop_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; alu_enable = 1'b1; alu_data_out = 32'h55;
    tick();
    idle_inputs();
    check("post_flush_data", out_data, 32'h55);

    // Reset mid-operation loses entries
    rst_n = 1'b0; tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    rst_n = 1'b1;

`ifdef CORE_EXU_RESULT_FWD_EN
    out_ready = 1'b0; in_valid = 1'b1; alu_enable = 1'b1; in_rd = 5'd3; in_rd_wen = 1'b1;
    alu_data_out = 32'h10; tick();
    check("fwd_one_data", fwd_data, 32'h10);
    alu_data_out = 32'h20; tick();
    idle_inputs();
    check("fwd_valid", 32'(fwd_valid), 32'd1);
    check("fwd_rd", 32'(fwd_rd), 32'd3);
    check("fwd_data", fwd_data, 32'h20);
    flush = 1'b1; tick(); flush = 1'b0; #1;
    check("fwd_flush_valid", 32'(fwd_valid), 32'd0);
    check("fwd_flush_data", fwd_data, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
